parity_frame_rx: RTL and testbench

Serial receiver that deframes an idle-high, LSB-first bit stream (start bit, DATA_BITS data bits, one parity bit, one stop bit) and checks the parity by XOR accumulation. It is the receiving end of the XOR parity path: an upstream transmitter generates the parity bit, and this block recomputes it and flags any mismatch. It sits between a board pin (or a looped-back transmitter) and the lab's display or result logic.

---
 rtl/parity_frame_rx_pkg.sv | 27 ++
 rtl/parity_frame_rx_if.sv | 29 ++
 rtl/parity_frame_rx_bit_sync.sv | 22 ++
 rtl/parity_frame_rx.sv | 136 +++++++++++++
 tb/tb_parity_frame_rx.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/parity_frame_rx_pkg.sv
// Shared types and constants for the parity frame receiver.
// PARITY_FRAME_RX_ODD_EN selects odd parity; even parity otherwise.
package parity_frame_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

`ifdef PARITY_FRAME_RX_ODD_EN
    localparam logic EXPECTED_PARITY = 1'b1;
`else
    localparam logic EXPECTED_PARITY = 1'b0;
`endif

    function automatic int cnt_w(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

    function automatic int idx_w(input int data_bits);
        return $clog2(data_bits + 1);
    endfunction

endpackage

// File: rtl/parity_frame_rx_if.sv
// Result bundle of the parity frame receiver.
// master drives the results, slave consumes them.
interface parity_frame_rx_if #(
    parameter int DATA_BITS = 8
);

    logic [DATA_BITS-1:0] data_o;
    logic                 valid_o;
    logic                 parity_err_o;
    logic                 frame_err_o;
    logic                 busy_o;

    modport master (
        output data_o,
        output valid_o,
        output parity_err_o,
        output frame_err_o,
        output busy_o
    );

    modport slave (
        input data_o,
        input valid_o,
        input parity_err_o,
        input frame_err_o,
        input busy_o
    );

endinterface

// File: rtl/parity_frame_rx_bit_sync.sv
// Two-flop synchronizer; resets high so an idle line
// never looks like a start edge on reset release.
module bit_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/parity_frame_rx.sv
// Idle-high LSB-first serial receiver with XOR parity check.
// Build with PARITY_FRAME_RX_ODD_EN defined for odd parity.
module parity_frame_rx
    import parity_frame_rx_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx_i,
    parity_frame_rx_if.master        rx_if
);

    localparam int CW = cnt_w(CLKS_PER_BIT);
    localparam int IW = idx_w(DATA_BITS);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] sh_next;
    logic                 acc;
    logic                 rx_s;
    logic                 hist;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 busy_q;

    bit_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_i),
        .q     (rx_s)
    );

    // New bit enters at the MSB so the word ends up LSB-first.
    always_comb begin
        sh_next = shreg >> 1;
        sh_next[DATA_BITS-1] = rx_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            acc     <= 1'b0;
            hist    <= 1'b1;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            hist    <= rx_s;
            valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (hist && !rx_s) begin
                        state  <= START;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                            idx   <= '0;
                            acc   <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        shreg <= sh_next;
                        acc   <= acc ^ rx_s;
                        idx   <= idx + 1'b1;
                        if (idx == IDX_LAST) state <= PARITY;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        acc   <= acc ^ rx_s;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        data_q  <= shreg;
                        perr_q  <= (acc != EXPECTED_PARITY);
                        ferr_q  <= !rx_s;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                        // A held-low line (break) must go high before a new start.
                        if (!rx_s) hist <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx_if.data_o       = data_q;
    assign rx_if.valid_o      = valid_q;
    assign rx_if.parity_err_o = perr_q;
    assign rx_if.frame_err_o  = ferr_q;
    assign rx_if.busy_o       = busy_q;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx (DATA_BITS=8, CLKS_PER_BIT=16).
// Honours PARITY_FRAME_RX_ODD_EN when it is defined for the build.
module tb_parity_frame_rx;

`ifdef PARITY_FRAME_RX_ODD_EN
    localparam logic ODD = 1'b1;
`else
    localparam logic ODD = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic rx;
    int   cyc;
    int   n_valid;
    int   last_valid_cyc;
    int   busy_cyc;
    int   n_tests;
    int   n_fail;

    parity_frame_rx_if #(.DATA_BITS(8)) rif ();

    parity_frame_rx #(
        .DATA_BITS    (8),
        .CLKS_PER_BIT (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_i  (rx),
        .rx_if (rif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        n_valid        = 0;
        last_valid_cyc = 0;
        busy_cyc       = 0;
    end

    always @(negedge clk) begin
        if (rif.valid_o === 1'b1) begin
            n_valid        = n_valid + 1;
            last_valid_cyc = cyc;
        end
        if (rif.busy_o === 1'b1) busy_cyc = busy_cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p,
                              input logic s);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(s);
    endtask

    task automatic check_frame(input string tag, input int t0, input int v0,
                               input logic [7:0] d, input logic pe,
                               input logic fe);
        chk({tag, "_cnt"}, n_valid, v0 + 1);
        chk({tag, "_lat"}, last_valid_cyc - t0, 171);
        chk({tag, "_data"}, rif.data_o, d);
        chk({tag, "_perr"}, rif.parity_err_o, pe);
        chk({tag, "_ferr"}, rif.frame_err_o, fe);
        chk({tag, "_busy"}, rif.busy_o, 1'b0);
    endtask

    initial begin
        int t0;
        int t1;
        int v0;
        int bc0;
        logic [7:0] d1;
        n_tests = 0;
        n_fail  = 0;
        rx      = 1'b1;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data", rif.data_o, 8'h00);
        chk("rst_valid", rif.valid_o, 1'b0);
        chk("rst_perr", rif.parity_err_o, 1'b0);
        chk("rst_ferr", rif.frame_err_o, 1'b0);
        chk("rst_busy", rif.busy_o, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_busy", rif.busy_o, 1'b0);

        // good frame
        t0 = cyc; v0 = n_valid;
        send_frame(8'hA5, 1'b0, 1'b1);
        check_frame("good", t0, v0, 8'hA5, ODD, 1'b0);

        // bad parity (correct under odd parity)
        t0 = cyc; v0 = n_valid;
        send_frame(8'h01, 1'b0, 1'b1);
        check_frame("par", t0, v0, 8'h01, !ODD, 1'b0);

        // bad stop followed by a long break
        t0 = cyc; v0 = n_valid;
        send_frame(8'h3C, 1'b0, 1'b0);
        check_frame("stop", t0, v0, 8'h3C, ODD, 1'b1);
        bc0 = busy_cyc; v0 = n_valid;
        rx = 1'b0;
        repeat (40 * 16) @(negedge clk);
        chk("brk_busy", busy_cyc - bc0, 0);
        chk("brk_valid", n_valid, v0);
        rx = 1'b1;
        repeat (32) @(negedge clk);
        t0 = cyc; v0 = n_valid;
        send_frame(8'h55, 1'b0, 1'b1);
        check_frame("after_brk", t0, v0, 8'h55, ODD, 1'b0);

        // glitch: 4 cycles low is a false start
        bc0 = busy_cyc; v0 = n_valid;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("gl_busycyc", busy_cyc - bc0, 8);
        chk("gl_busy", rif.busy_o, 1'b0);
        chk("gl_valid", n_valid, v0);
        chk("gl_data", rif.data_o, 8'h55);
        chk("gl_ferr", rif.frame_err_o, 1'b0);

        // reset during data bit 3 of 0xFF
        v0 = n_valid;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_data", rif.data_o, 8'h00);
        chk("mrst_busy", rif.busy_o, 1'b0);
        chk("mrst_valid", rif.valid_o, 1'b0);
        chk("mrst_perr", rif.parity_err_o, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (16) @(negedge clk);
        chk("mrst_nov", n_valid, v0);
        t0 = cyc; v0 = n_valid;
        send_frame(8'h81, 1'b0, 1'b1);
        check_frame("post_rst", t0, v0, 8'h81, ODD, 1'b0);

        // back-to-back frames
        repeat (16) @(negedge clk);
        t0 = cyc; v0 = n_valid;
        send_frame(8'h12, 1'b0, 1'b1);
        t1 = last_valid_cyc;
        d1 = rif.data_o;
        chk("b2b_d1", d1, 8'h12);
        chk("b2b_lat1", t1 - t0, 171);
        send_frame(8'h34, 1'b1, 1'b1);
        chk("b2b_cnt", n_valid, v0 + 2);
        chk("b2b_gap", last_valid_cyc - t1, 11 * 16);
        chk("b2b_d2", rif.data_o, 8'h34);
        chk("b2b_perr", rif.parity_err_o, ODD);
        chk("b2b_ferr", rif.frame_err_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
